serializer: RTL and testbench

SERIALIZER -- requirements
Module: serializer

---
 rtl/serializer.sv | 140 ++++++++++++++
 tb/tb_serializer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer.sv
`default_nettype none
// ============================================================================
// Module   : serializer
// Purpose  : Pulls bytes from an upstream queue one at a time and shifts each
//            one out MSB first. Each byte takes 11 cycles: a one-cycle
//            dequeue strobe, a one-cycle load, eight shift cycles and a
//            one-cycle done pulse.
//
// Ports    : clock_10        in   10 kHz system clock, rising-edge active
//            reset           in   asynchronous, active-high reset
//            enable_in       in   permission to start a new byte
//            len_in    [3:0] in   upstream queue occupancy (0..8)
//            data_in   [7:0] in   upstream byte, valid the cycle after deq_out
//            deq_out         out  dequeue strobe to the upstream queue
//            serial_out      out  serial data bit
//            valid_out       out  serial_out carries a valid bit
//            done_out        out  one-cycle pulse after the last bit of a byte
//            busy_out        out  FSM is not idle
//            bytes_sent_out [7:0] out count of completed bytes, wraps at 256
//
// Revision : 1.0 - initial release
// ============================================================================
module serializer (
    input  logic       clock_10,
    input  logic       reset,
    input  logic       enable_in,
    input  logic [3:0] len_in,
    input  logic [7:0] data_in,
    output logic       deq_out,
    output logic       serial_out,
    output logic       valid_out,
    output logic       done_out,
    output logic       busy_out,
    output logic [7:0] bytes_sent_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DEQ   = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [2:0] C_LAST_BIT = 3'd7;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_shift_reg;
    logic [7:0] w_shift_next;
    logic [2:0] r_bit_cnt;
    logic [2:0] w_bit_cnt_next;
    logic [7:0] r_bytes_sent;
    logic [7:0] w_bytes_sent_next;
    logic       w_start;

    // A new byte may only be requested when the queue is non-empty, so an
    // empty queue is never dequeued.
    assign w_start = enable_in && (len_in != 4'd0);

    // ------------------------------------------------------------------------
    // State register. The asynchronous reset forces IDLE and clears the
    // datapath at once; since every output is decoded from these registers,
    // the outputs drop to zero without waiting for a clock edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_10 or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_shift_reg  <= 8'd0;
            r_bit_cnt    <= 3'd0;
            r_bytes_sent <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_shift_reg  <= w_shift_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_bytes_sent <= w_bytes_sent_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic.
    // len_in/enable_in are only looked at in IDLE and DONE; a byte that has
    // been dequeued always runs to completion.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_shift_next      = r_shift_reg;
        w_bit_cnt_next    = r_bit_cnt;
        w_bytes_sent_next = r_bytes_sent;

        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_next = DEQ;
                end
            end

            DEQ: begin
                // The queue presents the byte during the following cycle.
                w_state_next = LOAD;
            end

            LOAD: begin
                w_shift_next   = data_in;
                w_bit_cnt_next = 3'd0;
                w_state_next   = SHIFT;
            end

            SHIFT: begin
                w_shift_next   = {r_shift_reg[6:0], 1'b0};
                w_bit_cnt_next = r_bit_cnt + 3'd1;
                if (r_bit_cnt == C_LAST_BIT) begin
                    w_state_next = DONE;
                end
            end

            DONE: begin
                w_bytes_sent_next = r_bytes_sent + 8'd1;
                w_state_next      = w_start ? DEQ : IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs: pure decodes of registered state.
    // ------------------------------------------------------------------------
    assign deq_out        = (r_state == DEQ);
    assign valid_out      = (r_state == SHIFT);
    assign serial_out     = (r_state == SHIFT) && r_shift_reg[7];
    assign done_out       = (r_state == DONE);
    assign busy_out       = (r_state != IDLE);
    assign bytes_sent_out = r_bytes_sent;

endmodule

`default_nettype wire

// File: tb/tb_serializer.sv
`timescale 1us/1ns
`default_nettype none
// ============================================================================
// Module   : tb_serializer
// Purpose  : Self-checking bench for serializer. An upstream byte queue is
//            modelled in the bench; every observed cycle is compared against a
//            timing model in which each byte occupies 11 cycles
//            (deq, load, 8 bits MSB first, done).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serializer;

    logic       clock_10  = 1'b0;
    logic       reset     = 1'b1;
    logic       enable_in = 1'b0;
    logic [3:0] len_in    = 4'd0;
    logic [7:0] data_in   = 8'd0;
    logic       deq_out;
    logic       serial_out;
    logic       valid_out;
    logic       done_out;
    logic       busy_out;
    logic [7:0] bytes_sent_out;

    serializer dut (
        .clock_10       (clock_10),
        .reset          (reset),
        .enable_in      (enable_in),
        .len_in         (len_in),
        .data_in        (data_in),
        .deq_out        (deq_out),
        .serial_out     (serial_out),
        .valid_out      (valid_out),
        .done_out       (done_out),
        .busy_out       (busy_out),
        .bytes_sent_out (bytes_sent_out)
    );

    // 10 kHz: 100 us period
    always #50 clock_10 = ~clock_10;

    typedef struct packed {
        logic deq;
        logic valid;
        logic serial;
        logic done;
        logic busy;
    } obs_t;

    obs_t       trace[$];      // one entry per observed cycle
    logic [7:0] src_q[$];      // upstream queue contents
    logic [7:0] exp_bytes[$];  // bytes the model expects to see transmitted
    int         underflows = 0;
    int         tests_run    = 0;
    int         tests_failed = 0;

    // ------------------------------------------------------------------------
    // Upstream queue helpers
    // ------------------------------------------------------------------------
    task automatic update_len();
        len_in = (src_q.size() > 8) ? 4'd8 : 4'(src_q.size());
    endtask

    // Advance one rising edge, then observe at the falling edge. When the DUT
    // is strobing deq_out, the queue pops and presents the byte for the
    // following (load) cycle.
    task automatic step();
        obs_t o;
        @(posedge clock_10);
        @(negedge clock_10);
        o.deq    = deq_out;
        o.valid  = valid_out;
        o.serial = serial_out;
        o.done   = done_out;
        o.busy   = busy_out;
        trace.push_back(o);
        if (deq_out) begin
            if (src_q.size() == 0) begin
                underflows++;
            end else begin
                data_in = src_q.pop_front();
            end
            update_len();
        end
    endtask

    task automatic do_reset();
        @(negedge clock_10);
        reset     = 1'b1;
        enable_in = 1'b0;
        data_in   = 8'd0;
        src_q.delete();
        exp_bytes.delete();
        update_len();
        repeat (2) @(negedge clock_10);
        reset = 1'b0;
        trace.delete();
        underflows = 0;
    endtask

    // ------------------------------------------------------------------------
    // Reference model: cycle k after the start edge, with n bytes sent
    // back to back. Phase 0 = dequeue, 1 = load, 2..9 = bits 7..0, 10 = done.
    // ------------------------------------------------------------------------
    function automatic obs_t model_cycle(int k, int n);
        obs_t       e;
        int         ph;
        logic [7:0] b;
        e = '0;
        if (k < 11 * n) begin
            ph     = k % 11;
            b      = exp_bytes[k / 11];
            e.busy = 1'b1;
            e.deq  = (ph == 0);
            e.done = (ph == 10);
            if (ph >= 2 && ph <= 9) begin
                e.valid  = 1'b1;
                e.serial = b[3'(9 - ph)];
            end
        end
        return e;
    endfunction

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        logic [5:0] got;
        // Outputs while reset is held from time zero, before any clock edge.
        #10;
        got = {deq_out, serial_out, valid_out, done_out, busy_out, |bytes_sent_out};
        tests_run++;
        if (got !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_initial: deq/ser/val/done/busy/sent!=0 = %b, required 000000", got);
        end
        // Start conditions present while reset is held must not start the FSM.
        enable_in = 1'b1;
        src_q.push_back(8'h11);
        update_len();
        repeat (3) step();
        foreach (trace[k]) begin
            tests_run++;
            if (trace[k] !== obs_t'(0)) begin
                tests_failed++;
                $display("FAIL reset_held cycle %0d: got %b, required 00000", k, trace[k]);
            end
        end
        tests_run++;
        if (bytes_sent_out !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_bytes_sent: got %0d, required 0", bytes_sent_out);
        end
        do_reset();
    endtask

    task automatic test_single();
        obs_t e;
        src_q     = '{8'hA5};
        exp_bytes = '{8'hA5};
        update_len();
        enable_in = 1'b1;
        repeat (14) step();
        foreach (trace[k]) begin
            e = model_cycle(k, 1);
            tests_run++;
            if (trace[k] !== e) begin
                tests_failed++;
                $display("FAIL single_trace cycle %0d: got deq/val/ser/done/busy=%b, required %b", k, trace[k], e);
            end
        end
        tests_run++;
        if (bytes_sent_out !== 8'd1) begin
            tests_failed++;
            $display("FAIL single_bytes_sent: got %0d, required 1", bytes_sent_out);
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        obs_t e;
        int   deqs = 0;
        src_q     = '{8'h3C, 8'hFF};
        exp_bytes = '{8'h3C, 8'hFF};
        update_len();
        enable_in = 1'b1;
        repeat (26) step();
        foreach (trace[k]) begin
            e = model_cycle(k, 2);
            if (trace[k].deq) deqs++;
            tests_run++;
            if (trace[k] !== e) begin
                tests_failed++;
                $display("FAIL b2b_trace cycle %0d: got %b, required %b", k, trace[k], e);
            end
        end
        tests_run++;
        if (deqs != 2) begin
            tests_failed++;
            $display("FAIL b2b_deq_count: got %0d, required 2", deqs);
        end
        tests_run++;
        if (bytes_sent_out !== 8'd2) begin
            tests_failed++;
            $display("FAIL b2b_bytes_sent: got %0d, required 2", bytes_sent_out);
        end
        do_reset();
    endtask

    task automatic test_random();
        obs_t       e;
        int         n;
        logic [7:0] b;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                src_q.push_back(b);
                exp_bytes.push_back(b);
            end
            update_len();
            enable_in = 1'b1;
            repeat (11 * n + 4) step();
            foreach (trace[k]) begin
                e = model_cycle(k, n);
                tests_run++;
                if (trace[k] !== e) begin
                    tests_failed++;
                    $display("FAIL random%0d_trace cycle %0d (n=%0d): got %b, required %b", it, k, n, trace[k], e);
                end
            end
            tests_run++;
            if (bytes_sent_out !== 8'(n) || underflows != 0) begin
                tests_failed++;
                $display("FAIL random%0d_count: bytes_sent=%0d underflows=%0d, required %0d and 0",
                         it, bytes_sent_out, underflows, n);
            end
            do_reset();
        end
    endtask

    task automatic test_enable_drop();
        obs_t e;
        int   deqs = 0;
        // A second byte is waiting, so only enable_in keeps it from starting.
        src_q     = '{8'h81, 8'h55};
        exp_bytes = '{8'h81};
        update_len();
        enable_in = 1'b1;
        repeat (5) step();   // cycle 4 is the third shift cycle
        enable_in = 1'b0;
        repeat (11) step();
        foreach (trace[k]) begin
            e = model_cycle(k, 1);
            if (trace[k].deq) deqs++;
            tests_run++;
            if (trace[k] !== e) begin
                tests_failed++;
                $display("FAIL drop_trace cycle %0d: got %b, required %b", k, trace[k], e);
            end
        end
        tests_run++;
        if (deqs != 1 || bytes_sent_out !== 8'd1) begin
            tests_failed++;
            $display("FAIL drop_counts: deqs=%0d bytes_sent=%0d, required 1 and 1", deqs, bytes_sent_out);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_byte();
        obs_t       e;
        logic [5:0] got;
        src_q     = '{8'hC3, 8'h96};
        exp_bytes = '{8'hC3, 8'h96};
        update_len();
        enable_in = 1'b1;
        repeat (17) step();  // cycle 16 is the 4th shift cycle of the second byte
        foreach (trace[k]) begin
            e = model_cycle(k, 2);
            tests_run++;
            if (trace[k] !== e) begin
                tests_failed++;
                $display("FAIL midrst_trace cycle %0d: got %b, required %b", k, trace[k], e);
            end
        end
        tests_run++;
        if (bytes_sent_out !== 8'd1) begin
            tests_failed++;
            $display("FAIL midrst_pre_count: got %0d, required 1", bytes_sent_out);
        end
        // Assert reset between edges and look before the next edge arrives.
        #5;
        reset = 1'b1;
        #1;
        got = {deq_out, serial_out, valid_out, done_out, busy_out, |bytes_sent_out};
        tests_run++;
        if (got !== 6'b0) begin
            tests_failed++;
            $display("FAIL midrst_immediate: deq/ser/val/done/busy/sent!=0 = %b, required 000000", got);
        end
        enable_in = 1'b0;
        src_q     = '{8'h4E};
        exp_bytes = '{8'h4E};
        update_len();
        repeat (2) step();
        @(negedge clock_10);
        reset = 1'b0;
        trace.delete();
        // Data waiting but no enable: no dequeue may happen.
        repeat (5) step();
        foreach (trace[k]) begin
            tests_run++;
            if (trace[k] !== obs_t'(0)) begin
                tests_failed++;
                $display("FAIL midrst_idle cycle %0d: got %b, required 00000", k, trace[k]);
            end
        end
        trace.delete();
        enable_in = 1'b1;
        repeat (13) step();
        foreach (trace[k]) begin
            e = model_cycle(k, 1);
            tests_run++;
            if (trace[k] !== e) begin
                tests_failed++;
                $display("FAIL midrst_restart cycle %0d: got %b, required %b", k, trace[k], e);
            end
        end
        tests_run++;
        if (bytes_sent_out !== 8'd1) begin
            tests_failed++;
            $display("FAIL midrst_post_count: got %0d, required 1", bytes_sent_out);
        end
        do_reset();
    endtask

    task automatic test_wrap_and_empty();
        obs_t       e;
        logic [7:0] b;
        int         errs = 0;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            src_q.push_back(b);
            exp_bytes.push_back(b);
        end
        update_len();
        enable_in = 1'b1;
        for (int k = 0; k < 11 * 256 + 3; k++) begin
            step();
            if (k == 11 * 255) begin
                tests_run++;
                if (bytes_sent_out !== 8'd255) begin
                    tests_failed++;
                    $display("FAIL wrap_255: got %0d, required 255", bytes_sent_out);
                end
            end
            if (k == 11 * 256) begin
                tests_run++;
                if (bytes_sent_out !== 8'd0) begin
                    tests_failed++;
                    $display("FAIL wrap_0: got %0d, required 0", bytes_sent_out);
                end
            end
        end
        foreach (trace[k]) begin
            e = model_cycle(k, 256);
            if (trace[k] !== e) begin
                errs++;
                if (errs <= 5) $display("FAIL wrap_trace cycle %0d: got %b, required %b", k, trace[k], e);
            end
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL wrap_trace_total: %0d mismatching cycles, required 0", errs);
        end
        tests_run++;
        if (underflows != 0) begin
            tests_failed++;
            $display("FAIL wrap_underflow: got %0d, required 0", underflows);
        end
        // Queue now empty with enable held: nothing may start.
        trace.delete();
        repeat (10) step();
        foreach (trace[k]) begin
            tests_run++;
            if (trace[k].deq !== 1'b0 || trace[k].busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL empty_idle cycle %0d: deq=%b busy=%b, required 0 0",
                         k, trace[k].deq, trace[k].busy);
            end
        end
        do_reset();
    endtask

    // ------------------------------------------------------------------------
    // Sequencer and watchdog
    // ------------------------------------------------------------------------
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_enable_drop();
        test_reset_mid_byte();
        test_wrap_and_empty();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #(100 * 20000);
        $display("FAIL watchdog: simulation exceeded 20000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
